// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: bubble encoding, default reset vector and
// the next-PC select codes used by the IF stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    PCSEL_SEQ    = 2'd0,
    PCSEL_BRANCH = 2'd1,
    PCSEL_JUMP   = 2'd2,
    PCSEL_JR     = 2'd3
  } pcsel_e;

endpackage

// File: rtl/ifid_reg.sv
// Pipeline register between two stages carrying instruction, PC+4 and valid.
// Hold freezes the contents; flush loads a NOP bubble.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_hold,
  input  logic                i_flush,
  input  logic [31:0]         i_instr,
  input  logic [PC_WIDTH-1:0] i_pc_plus4,
  input  logic                i_valid,
  output logic [31:0]         o_instr,
  output logic [PC_WIDTH-1:0] o_pc_plus4,
  output logic                o_valid
);

  logic [31:0]         r_instr;
  logic [PC_WIDTH-1:0] r_pc_plus4;
  logic                r_valid;

  // Hold has priority: a stalled stage must keep its instruction intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= '0;
      r_valid    <= 1'b0;
    end else if (!i_hold) begin
      if (i_flush) begin
        r_instr    <= NOP_INSTR;
        r_pc_plus4 <= '0;
        r_valid    <= 1'b0;
      end else begin
        r_instr    <= i_instr;
        r_pc_plus4 <= i_pc_plus4;
        r_valid    <= i_valid;
      end
    end
  end

  assign o_instr    = r_instr;
  assign o_pc_plus4 = r_pc_plus4;
  assign o_valid    = r_valid;

endmodule

// File: rtl/pc_fetch_unit.sv
// MIPS instruction-fetch stage: PC register, prioritised next-PC select,
// IF/ID register and a count of valid instructions fetched.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_stall,
  input  logic                i_branch_taken,
  input  logic [PC_WIDTH-1:0] i_branch_target,
  input  logic                i_jump,
  input  logic [25:0]         i_jump_index,
  input  logic                i_jr,
  input  logic [PC_WIDTH-1:0] i_jr_target,
  input  logic [31:0]         i_imem_instr,
  output logic [PC_WIDTH-1:0] o_imem_addr,
  output logic                o_imem_stall,
  output logic [31:0]         o_ifid_instr,
  output logic [PC_WIDTH-1:0] o_ifid_pc_plus4,
  output logic                o_ifid_valid,
  output logic [31:0]         o_fetch_count
);

  function automatic logic [PC_WIDTH-1:0] word_align(input logic [PC_WIDTH-1:0] a);
    return {a[PC_WIDTH-1:2], 2'b00};
  endfunction

  logic [PC_WIDTH-1:0] r_pc;
  logic [31:0]         r_fetch_count;
  pcsel_e              w_sel;
  logic [PC_WIDTH-1:0] w_pc_plus4;
  logic [PC_WIDTH-1:0] w_jump_tgt;
  logic [PC_WIDTH-1:0] w_next_pc;
  logic                w_redirect;

  assign w_pc_plus4 = r_pc + PC_WIDTH'(4);
  // J/JAL keeps the 256 MB region of the jump's own PC+4, held in IF/ID.
  assign w_jump_tgt = PC_WIDTH'({o_ifid_pc_plus4[PC_WIDTH-1 -: 4], i_jump_index, 2'b00});

  always_comb begin
    w_sel = PCSEL_SEQ;
    if (i_jr)                w_sel = PCSEL_JR;
    else if (i_jump)         w_sel = PCSEL_JUMP;
    else if (i_branch_taken) w_sel = PCSEL_BRANCH;
  end

  always_comb begin
    w_next_pc = w_pc_plus4;
    case (w_sel)
      PCSEL_JR:     w_next_pc = word_align(i_jr_target);
      PCSEL_JUMP:   w_next_pc = word_align(w_jump_tgt);
      PCSEL_BRANCH: w_next_pc = word_align(i_branch_target);
      default:      w_next_pc = w_pc_plus4;
    endcase
  end

  assign w_redirect = (w_sel != PCSEL_SEQ) && !i_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= RESET_PC;
      r_fetch_count <= '0;
    end else if (!i_stall) begin
      r_pc <= w_next_pc;
      if (!w_redirect) r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  ifid_reg #(.PC_WIDTH(PC_WIDTH)) u_ifid (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_hold     (i_stall),
    .i_flush    (w_redirect),
    .i_instr    (i_imem_instr),
    .i_pc_plus4 (w_pc_plus4),
    .i_valid    (1'b1),
    .o_instr    (o_ifid_instr),
    .o_pc_plus4 (o_ifid_pc_plus4),
    .o_valid    (o_ifid_valid)
  );

  assign o_imem_addr   = r_pc;
  assign o_imem_stall  = i_stall;
  assign o_fetch_count = r_fetch_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: sequential fetch, redirect priority,
// stall hold, PC wrap-around and asynchronous reset.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst2_n = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] br_tgt = '0;
  logic        jmp = 1'b0;
  logic [25:0] jidx = '0;
  logic        jr = 1'b0;
  logic [31:0] jr_tgt = '0;

  logic [31:0] mem [0:1023];

  logic [31:0] addr1, instr1, pc4_1, cnt1, imem1;
  logic        valid1, istall1;
  logic [31:0] addr2, instr2, pc4_2, cnt2, imem2;
  logic        valid2, istall2;

  int n_chk = 0;
  int n_err = 0;

  assign imem1 = mem[addr1[11:2]];
  assign imem2 = mem[addr2[11:2]];

  always #5 clk = ~clk;

  pc_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .i_stall(stall),
    .i_branch_taken(br), .i_branch_target(br_tgt),
    .i_jump(jmp), .i_jump_index(jidx), .i_jr(jr), .i_jr_target(jr_tgt),
    .i_imem_instr(imem1), .o_imem_addr(addr1), .o_imem_stall(istall1),
    .o_ifid_instr(instr1), .o_ifid_pc_plus4(pc4_1), .o_ifid_valid(valid1),
    .o_fetch_count(cnt1)
  );

  pc_fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFF8)) dut_top (
    .clk(clk), .rst_n(rst2_n), .i_stall(stall),
    .i_branch_taken(br), .i_branch_target(br_tgt),
    .i_jump(jmp), .i_jump_index(jidx), .i_jr(jr), .i_jr_target(jr_tgt),
    .i_imem_instr(imem2), .o_imem_addr(addr2), .o_imem_stall(istall2),
    .o_ifid_instr(instr2), .o_ifid_pc_plus4(pc4_2), .o_ifid_valid(valid2),
    .o_fetch_count(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ctl();
    stall = 1'b0; br = 1'b0; br_tgt = '0; jmp = 1'b0; jidx = '0; jr = 1'b0; jr_tgt = '0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]     = 32'h0253_8820;
    mem[1]     = 32'h00A6_2020;
    mem[2]     = 32'h014B_4820;
    mem[6]     = 32'h01AE_6020;
    mem[7]     = 32'h0085_1020;
    mem[16]    = 32'h8C08_0004;
    mem[10'h3FE] = 32'h1111_1111;
    mem[10'h3FF] = 32'h2222_2222;

    #1;
    check("rst_addr",  addr1, 32'h0);
    check("rst_valid", {31'b0, valid1}, 32'h0);
    check("rst_count", cnt1, 32'h0);
    check("rst_instr", instr1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three sequential fetches
    step(); step(); step();
    check("seq_instr", instr1, 32'h014B_4820);
    check("seq_pc4",   pc4_1, 32'h0000_000C);
    check("seq_count", cnt1, 32'd3);
    check("seq_valid", {31'b0, valid1}, 32'h1);
    check("seq_addr",  addr1, 32'h0000_000C);

    // J to word 6
    jmp = 1'b1; jidx = 26'd6;
    step();
    check("j_addr",   addr1, 32'h0000_0018);
    check("j_valid",  {31'b0, valid1}, 32'h0);
    check("j_instr",  instr1, 32'h0);
    check("j_pc4",    pc4_1, 32'h0);
    check("j_count",  cnt1, 32'd3);
    clear_ctl();
    step();
    check("j_tinstr", instr1, 32'h01AE_6020);
    check("j_tpc4",   pc4_1, 32'h0000_001C);
    check("j_tcount", cnt1, 32'd4);
    step();
    check("seq2_instr", instr1, 32'h0085_1020);
    check("seq2_addr",  addr1, 32'h0000_0020);

    // JR beats jump and branch; low target bits are forced to zero
    jr = 1'b1; jr_tgt = 32'h0000_001B; jmp = 1'b1; jidx = 26'h10; br = 1'b1; br_tgt = 32'h40;
    step();
    check("jr_addr",  addr1, 32'h0000_0018);
    check("jr_valid", {31'b0, valid1}, 32'h0);
    check("jr_count", cnt1, 32'd5);
    clear_ctl();
    step();
    check("jr_tinstr", instr1, 32'h01AE_6020);

    // Jump beats branch
    jmp = 1'b1; jidx = 26'h10; br = 1'b1; br_tgt = 32'h80;
    step();
    check("jb_addr",  addr1, 32'h0000_0040);
    check("jb_valid", {31'b0, valid1}, 32'h0);
    clear_ctl();
    step();
    check("jb_tinstr", instr1, 32'h8C08_0004);
    check("jb_tpc4",   pc4_1, 32'h0000_0044);
    check("jb_count",  cnt1, 32'd7);

    // Stall two cycles with a pending branch
    stall = 1'b1; br = 1'b1; br_tgt = 32'h0000_0040;
    #1;
    check("st_imem_stall", {31'b0, istall1}, 32'h1);
    for (int k = 0; k < 2; k++) begin
      step();
      check("st_addr",  addr1, 32'h0000_0044);
      check("st_instr", instr1, 32'h8C08_0004);
      check("st_pc4",   pc4_1, 32'h0000_0044);
      check("st_count", cnt1, 32'd7);
    end
    stall = 1'b0;
    #1;
    check("st_imem_stall_lo", {31'b0, istall1}, 32'h0);
    step();
    check("br_addr",  addr1, 32'h0000_0040);
    check("br_valid", {31'b0, valid1}, 32'h0);
    check("br_count", cnt1, 32'd7);
    clear_ctl();

    // Asynchronous reset in the middle of a redirect
    jmp = 1'b1; jidx = 26'd6;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_addr",  addr1, 32'h0);
    check("ar_valid", {31'b0, valid1}, 32'h0);
    check("ar_count", cnt1, 32'h0);
    check("ar_instr", instr1, 32'h0);
    check("ar_pc4",   pc4_1, 32'h0);
    clear_ctl();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("ar_finstr", instr1, 32'h0253_8820);
    check("ar_fpc4",   pc4_1, 32'h0000_0004);
    check("ar_fcount", cnt1, 32'd1);
    check("ar_faddr",  addr1, 32'h0000_0004);

    // PC wrap near the top of the address space
    @(negedge clk);
    rst2_n = 1'b1;
    #1;
    check("wr_addr0", addr2, 32'hFFFF_FFF8);
    step();
    check("wr_addr1", addr2, 32'hFFFF_FFFC);
    check("wr_pc4_1", pc4_2, 32'hFFFF_FFFC);
    check("wr_instr1", instr2, 32'h1111_1111);
    step();
    check("wr_addr2", addr2, 32'h0000_0000);
    check("wr_pc4_2", pc4_2, 32'h0000_0000);
    check("wr_instr2", instr2, 32'h2222_2222);
    check("wr_count", cnt2, 32'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the program counter, drives the address of the combinational instruction memory, and selects the next PC: sequential, branch, J/JAL, or JR. It latches the fetched word into the IF/ID pipeline register. Redirects from ID flush IF/ID with one bubble. Hazard-unit stalls freeze both the PC and IF/ID.

## Interface
- PC_WIDTH, 32, width of PC and all address/target buses
- RESET_PC, 32'h0000_0000, PC value loaded on reset

- clk  in  1  single pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_stall  in  1  load-use stall from the hazard unit; freezes PC and IF/ID
- i_branch_taken  in  1  conditional branch resolved taken in ID
- i_branch_target  in  PC_WIDTH  branch target computed in ID
- i_jump  in  1  J/JAL decoded in ID
- i_jump_index  in  26  instr_index field of the J/JAL in ID
- i_jr  in  1  JR decoded in ID
- i_jr_target  in  PC_WIDTH  forwarded rs value for JR
- i_imem_instr  in  32  instruction word returned combinationally by instruction memory
- o_imem_addr  out  PC_WIDTH  byte address to instruction memory; equals the PC register
- o_imem_stall  out  1  stall to instruction memory; equals i_stall
- o_ifid_instr  out  32  IF/ID instruction
- o_ifid_pc_plus4  out  PC_WIDTH  IF/ID PC+4 of that instruction
- o_ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- o_fetch_count  out  32  number of valid instructions latched into IF/ID since reset

## Operation
- PC register. Next-PC priority, evaluated every cycle when not stalled:
  1. i_jr: i_jr_target.
  2. i_jump: {o_ifid_pc_plus4[31:28], i_jump_index, 2'b00}.
  3. i_branch_taken: i_branch_target.
  4. Otherwise: PC + 4.
- All targets have bits [1:0] forced to 00.
- Redirect is any of i_jr, i_jump or i_branch_taken while i_stall = 0. On the same edge:
  - PC loads the target.
  - IF/ID loads a bubble: instr = 32'h0000_0000 (sll $0 NOP), pc_plus4 = 0, valid = 0.
  - The fetched sequential instruction is discarded.
- Normal edge (no stall, no redirect): IF/ID loads {i_imem_instr, PC+4, valid=1}, PC loads PC+4, and o_fetch_count increments by 1.
- Stall edge (i_stall = 1): PC, IF/ID and o_fetch_count all hold. Redirect inputs are ignored, because the ID instruction re-presents after the stall.
- PC+4 uses modulo-2^PC_WIDTH arithmetic. 32'hFFFF_FFFC wraps to 0.
- Addresses beyond memory depth are not checked here; memory aliasing on Address[11:2] applies.
- o_fetch_count wraps at 2^32.
- Asynchronous reset is immediate on rst_n falling, regardless of clk:
  - PC = RESET_PC; o_imem_addr = RESET_PC.
  - o_ifid_instr = 0, o_ifid_pc_plus4 = 0, o_ifid_valid = 0.
  - o_fetch_count = 0.
- Reset asserted mid-redirect or mid-stall discards that event. The first edge after release performs a normal fetch of RESET_PC.

## Timing
- Zero-cycle address path: o_imem_addr is the PC register output, and i_imem_instr is sampled on the same rising edge.
- Fetch latency: the instruction at PC appears on o_ifid_instr one cycle after PC is presented.
- Redirect penalty: exactly one bubble.
  - Jump in ID in cycle N.
  - Bubble in IF/ID in cycle N+1.
  - Target instruction in IF/ID in cycle N+2.
- Stall of k cycles holds the outputs for exactly k cycles. The first edge with i_stall = 0 resumes normally or redirects.
- o_imem_stall is combinational from i_stall; there is no register.

## Structure
- Shared package fetch_pkg holds:
  - NOP_INSTR = 32'h0000_0000
  - DEFAULT_RESET_PC
  - the next-PC select encoding (PCSEL_SEQ, PCSEL_BRANCH, PCSEL_JUMP, PCSEL_JR)
- Sub-module ifid_reg: the IF/ID register with stall (hold) and flush (bubble) controls. The ID stage reuses this register type.
- Top level holds the PC register, next-PC mux, priority encoder and fetch counter.

## Test plan
- Reset with program 0x02538820, 0x00A62020, 0x014B4820 at words 0–2:
  - o_imem_addr = 0, valid = 0, count = 0.
  - After 3 edges: IF/ID = 0x014B4820, pc_plus4 = 0x0C, count = 3.
- J 0x08000006 at PC 0x08:
  - On the edge with i_jump = 1 and i_jump_index = 6: PC goes to 0x18 and IF/ID becomes a bubble (valid = 0).
  - Next edge: IF/ID = 0x01AE6020, pc_plus4 = 0x1C.
- JR 0x03000008 with i_jr_target = 0x18, i_jump = 1 and i_branch_taken = 1 (target 0x40) all asserted together:
  - JR wins, so PC = 0x18 and one bubble is inserted.
- i_stall high for 2 cycles with i_branch_taken = 1:
  - PC, IF/ID and count are unchanged for 2 edges and o_imem_stall = 1.
  - On the first unstalled edge the branch redirects.
- PC preset near the top (RESET_PC = 32'hFFFF_FFF8), two normal edges:
  - PC sequence is FFFF_FFF8, FFFF_FFFC, 0000_0000.
  - IF/ID pc_plus4 = 0 after the second edge.
- rst_n pulled low mid-cycle during a redirect:
  - Outputs go to reset values immediately, without a clock edge.
  - After release, the first fetch is from RESET_PC.
